pipeline_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions and generates per-stage enables, bubbles and flushes.
- Provides EX-stage operand forwarding selects and same-cycle WB→ID regfile bypass.
- Freezes the pipe while data memory is not ready, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl_stage_track.sv | 90 +++++++++
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: controller state,
// EX forwarding select and the default register address width.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic              id_is_load;
  logic              id_is_jmp;
  logic              ex_br_taken;
  logic              mem_access;
  logic              mem_ready;

  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_bubble;
  logic              ex_mem_en;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              id_byp_a;
  logic              id_byp_b;
  logic [1:0]        ctrl_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_jmp, ex_br_taken, mem_access, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_jmp, ex_br_taken, mem_access, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_stage_track.sv
// Shadow copy of the EX/MEM/WB destination bookkeeping, advanced with the
// real pipeline registers so hazards can be judged without datapath access.
module hazard_stage_track #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_ex_en,
  input  logic          i_ex_bubble,
  input  logic          i_mem_en,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_rs,
  input  logic [AW-1:0] i_id_rt,
  input  logic          i_id_uses_rs,
  input  logic          i_id_uses_rt,
  input  logic          i_id_we,
  input  logic [AW-1:0] i_id_dst,
  input  logic          i_id_ld,
  output logic          o_ex_valid,
  output logic [AW-1:0] o_ex_rs,
  output logic [AW-1:0] o_ex_rt,
  output logic          o_ex_uses_rs,
  output logic          o_ex_uses_rt,
  output logic          o_ex_we,
  output logic [AW-1:0] o_ex_dst,
  output logic          o_ex_ld,
  output logic          o_mem_valid,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_dst,
  output logic          o_mem_ld,
  output logic          o_wb_valid,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_dst
);

  // A bubble clears the whole EX record so stale operand flags cannot forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ex_valid   <= 1'b0;
      o_ex_rs      <= '0;
      o_ex_rt      <= '0;
      o_ex_uses_rs <= 1'b0;
      o_ex_uses_rt <= 1'b0;
      o_ex_we      <= 1'b0;
      o_ex_dst     <= '0;
      o_ex_ld      <= 1'b0;
    end else if (i_ex_en) begin
      if (i_ex_bubble) begin
        o_ex_valid   <= 1'b0;
        o_ex_rs      <= '0;
        o_ex_rt      <= '0;
        o_ex_uses_rs <= 1'b0;
        o_ex_uses_rt <= 1'b0;
        o_ex_we      <= 1'b0;
        o_ex_dst     <= '0;
        o_ex_ld      <= 1'b0;
      end else begin
        o_ex_valid   <= i_id_valid;
        o_ex_rs      <= i_id_rs;
        o_ex_rt      <= i_id_rt;
        o_ex_uses_rs <= i_id_uses_rs;
        o_ex_uses_rt <= i_id_uses_rt;
        o_ex_we      <= i_id_we;
        o_ex_dst     <= i_id_dst;
        o_ex_ld      <= i_id_ld;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_mem_valid <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_dst   <= '0;
      o_mem_ld    <= 1'b0;
      o_wb_valid  <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_dst    <= '0;
    end else if (i_mem_en) begin
      o_mem_valid <= o_ex_valid;
      o_mem_we    <= o_ex_we;
      o_mem_dst   <= o_ex_dst;
      o_mem_ld    <= o_ex_ld;
      o_wb_valid  <= o_mem_valid;
      o_wb_we     <= o_mem_we;
      o_wb_dst    <= o_mem_dst;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stage enables,
// bubbles, flushes, EX forwarding, WB->ID bypass and saturating perf counters.
//   state         | meaning
//   ST_RUN        | pipeline flows freely
//   ST_LOAD_STALL | load-use: hold PC and IF/ID, bubble into EX
//   ST_FLUSH      | taken branch (EX) or jump (ID) redirect
//   ST_MEM_WAIT   | data memory busy, whole pipe frozen
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset_n,
  pipeline_hazard_ctrl_if.slave bus
);
  import pipeline_hazard_ctrl_pkg::*;

  logic              w_ex_valid, w_ex_uses_rs, w_ex_uses_rt, w_ex_we, w_ex_ld;
  logic [REG_AW-1:0] w_ex_rs, w_ex_rt, w_ex_dst, w_mem_dst, w_wb_dst;
  logic              w_mem_valid, w_mem_we, w_mem_ld, w_wb_valid, w_wb_we;
  logic              w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_bubble, w_ex_mem_en;
  logic              w_mem_wait, w_flush_ex, w_load_use, w_flush_id;
  logic              w_ld_hazard_a, w_ld_hazard_b;
  ctrl_state_e       r_state, w_state_nxt;
  fwd_sel_e          w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  hazard_stage_track #(.AW(REG_AW)) u_track (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_ex_en      (w_id_ex_en),
    .i_ex_bubble  (w_id_ex_bubble),
    .i_mem_en     (w_ex_mem_en),
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_uses_rs (bus.id_uses_rs),
    .i_id_uses_rt (bus.id_uses_rt),
    .i_id_we      (bus.id_wr_en),
    .i_id_dst     (bus.id_wr_addr),
    .i_id_ld      (bus.id_is_load),
    .o_ex_valid   (w_ex_valid),
    .o_ex_rs      (w_ex_rs),
    .o_ex_rt      (w_ex_rt),
    .o_ex_uses_rs (w_ex_uses_rs),
    .o_ex_uses_rt (w_ex_uses_rt),
    .o_ex_we      (w_ex_we),
    .o_ex_dst     (w_ex_dst),
    .o_ex_ld      (w_ex_ld),
    .o_mem_valid  (w_mem_valid),
    .o_mem_we     (w_mem_we),
    .o_mem_dst    (w_mem_dst),
    .o_mem_ld     (w_mem_ld),
    .o_wb_valid   (w_wb_valid),
    .o_wb_we      (w_wb_we),
    .o_wb_dst     (w_wb_dst)
  );

  assign w_mem_wait = bus.mem_access & ~bus.mem_ready & w_mem_valid;
  assign w_flush_ex = bus.ex_br_taken & w_ex_valid;
  assign w_flush_id = bus.id_valid & bus.id_is_jmp;
  assign w_load_use = w_ex_valid & w_ex_ld & w_ex_we & (w_ex_dst != '0) &
                      ((bus.id_uses_rs & (bus.id_rs == w_ex_dst)) |
                       (bus.id_uses_rt & (bus.id_rt == w_ex_dst)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_mem_wait)      w_state_nxt = ST_MEM_WAIT;
    else if (w_flush_ex) w_state_nxt = ST_FLUSH;
    else if (w_load_use) w_state_nxt = ST_LOAD_STALL;
    else if (w_flush_id) w_state_nxt = ST_FLUSH;
  end

  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b1;
    w_id_ex_bubble = 1'b0;
    w_ex_mem_en    = 1'b1;
    unique case (w_state_nxt)
      ST_MEM_WAIT: begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
      end
      ST_LOAD_STALL: begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_bubble = 1'b1;
      end
      ST_FLUSH: begin
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = w_flush_ex;
      end
      default: ;
    endcase
  end

  // A load still in MEM has no data yet; select the regfile rather than aluOut.
  function automatic fwd_sel_e pick_fwd(input logic uses, input logic [REG_AW-1:0] src);
    pick_fwd = FWD_REG;
    if (uses && src != '0) begin
      if (w_mem_valid && w_mem_we && w_mem_dst == src)
        pick_fwd = w_mem_ld ? FWD_REG : FWD_EXMEM;
      else if (w_wb_valid && w_wb_we && w_wb_dst == src)
        pick_fwd = FWD_MEMWB;
    end
  endfunction

  always_comb begin
    w_fwd_a = pick_fwd(w_ex_uses_rs, w_ex_rs);
    w_fwd_b = pick_fwd(w_ex_uses_rt, w_ex_rt);
  end

  assign w_ld_hazard_a = w_ex_uses_rs && w_ex_rs != '0 && w_mem_valid && w_mem_we &&
                         w_mem_ld && w_mem_dst == w_ex_rs;
  assign w_ld_hazard_b = w_ex_uses_rt && w_ex_rt != '0 && w_mem_valid && w_mem_we &&
                         w_mem_ld && w_mem_dst == w_ex_rt;

  a_no_load_fwd: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(w_ld_hazard_a || w_ld_hazard_b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_state_nxt == ST_LOAD_STALL || w_state_nxt == ST_MEM_WAIT) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_state_nxt == ST_FLUSH && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.fwd_a_sel    = w_fwd_a;
  assign bus.fwd_b_sel    = w_fwd_b;
  assign bus.id_byp_a     = bus.id_uses_rs & w_wb_valid & w_wb_we & (w_wb_dst == bus.id_rs) &
                            (bus.id_rs != '0);
  assign bus.id_byp_b     = bus.id_uses_rt & w_wb_valid & w_wb_we & (w_wb_dst == bus.id_rt) &
                            (bus.id_rt != '0);
  assign bus.ctrl_state   = r_state;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: an instruction-level pipeline model predicts the controller's
// outputs each cycle; a monitor compares them against the DUT.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 6;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_BRN = 4, K_JMP = 5, K_NOP = 6;

  typedef struct packed {
    logic v, urs, urt, we, ld, st, br, jmp;
    logic [4:0] rs, rt, dst;
  } instr_t;

  typedef struct packed {
    logic pc, ifid, flush, idex, bub, exmem;
    logic [1:0] fa, fb;
    logic ba, bb;
    logic [1:0] st;
    logic [CW-1:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus();
  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t   q[$];
  instr_t prog[$];
  instr_t id_i, ex_i, mem_i, wb_i;
  int     prev_cond, scnt, fcnt;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int kind, input int dst, input int rs, input int rt);
    instr_t t = '0;
    t.v  = 1'b1;
    t.rs = rs[4:0];
    t.rt = rt[4:0];
    case (kind)
      K_ALU: begin t.urs = 1; t.urt = 1; t.we = 1; t.dst = dst[4:0]; end
      K_LD:  begin t.urs = 1; t.we = 1; t.ld = 1; t.dst = dst[4:0]; end
      K_ST:  begin t.urs = 1; t.urt = 1; t.st = 1; end
      K_BR:  begin t.urs = 1; t.urt = 1; t.br = 1; end
      K_BRN: begin t.urs = 1; t.urt = 1; end
      K_JMP: begin t.jmp = 1; t.we = (dst != 0); t.dst = dst[4:0]; t.urs = (rs != 0); end
      default: ;
    endcase
    return t;
  endfunction

  function automatic instr_t fetch();
    int k;
    if (prog.size() > 0) return prog.pop_front();
    k = $urandom_range(0, 99);
    return mk(k < 35 ? K_ALU : k < 55 ? K_LD : k < 67 ? K_ST : k < 74 ? K_BR :
              k < 82 ? K_BRN : k < 88 ? K_JMP : K_NOP,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  // Youngest producer that already has its result wins; register 0 never forwards.
  function automatic logic [1:0] fsel(input logic u, input logic [4:0] s);
    if (!u || s == 0) return 2'd0;
    if (mem_i.v && mem_i.we && mem_i.dst == s) return mem_i.ld ? 2'd0 : 2'd1;
    if (wb_i.v && wb_i.we && wb_i.dst == s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic predict(input bit rdy, output exp_t e, output int cond);
    bit mw = mem_i.v && (mem_i.ld || mem_i.st) && !rdy;
    bit fe = ex_i.v && ex_i.br;
    bit lu = ex_i.v && ex_i.ld && ex_i.we && ex_i.dst != 0 &&
             ((id_i.urs && id_i.rs == ex_i.dst) || (id_i.urt && id_i.rt == ex_i.dst));
    bit fi = id_i.v && id_i.jmp;
    e = '0;
    e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1;
    if (mw)      begin cond = 3; e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; end
    else if (fe) begin cond = 2; e.flush = 1; e.bub = 1; end
    else if (lu) begin cond = 1; e.pc = 0; e.ifid = 0; e.bub = 1; end
    else if (fi) begin cond = 2; e.flush = 1; end
    else           cond = 0;
    e.fa = fsel(ex_i.urs, ex_i.rs);
    e.fb = fsel(ex_i.urt, ex_i.rt);
    e.ba = id_i.urs && id_i.rs != 0 && wb_i.v && wb_i.we && wb_i.dst == id_i.rs;
    e.bb = id_i.urt && id_i.rt != 0 && wb_i.v && wb_i.we && wb_i.dst == id_i.rt;
    e.st = prev_cond[1:0];
    e.sc = scnt[CW-1:0];
    e.fc = fcnt[CW-1:0];
  endtask

  task automatic drive(input bit rdy);
    bus.id_valid    = id_i.v;
    bus.id_rs       = id_i.rs;
    bus.id_rt       = id_i.rt;
    bus.id_uses_rs  = id_i.urs;
    bus.id_uses_rt  = id_i.urt;
    bus.id_wr_en    = id_i.we;
    bus.id_wr_addr  = id_i.dst;
    bus.id_is_load  = id_i.ld;
    bus.id_is_jmp   = id_i.jmp;
    bus.ex_br_taken = ex_i.v && ex_i.br;
    bus.mem_access  = mem_i.v && (mem_i.ld || mem_i.st);
    bus.mem_ready   = rdy;
  endtask

  task automatic advance(input exp_t e, input int cond);
    int sat = (1 << CW) - 1;
    if ((cond == 1 || cond == 3) && scnt < sat) scnt++;
    if (cond == 2 && fcnt < sat) fcnt++;
    prev_cond = cond;
    if (e.exmem) begin wb_i = mem_i; mem_i = ex_i; end
    if (e.idex) ex_i = e.bub ? '0 : id_i;
    if (e.flush)     id_i = '0;
    else if (e.ifid) id_i = fetch();
  endtask

  task automatic model_reset();
    id_i = '0; ex_i = '0; mem_i = '0; wb_i = '0;
    prev_cond = 0; scnt = 0; fcnt = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_en",        bus.pc_en,        e.pc);
        chk("if_id_en",     bus.if_id_en,     e.ifid);
        chk("if_id_flush",  bus.if_id_flush,  e.flush);
        chk("id_ex_en",     bus.id_ex_en,     e.idex);
        chk("id_ex_bubble", bus.id_ex_bubble, e.bub);
        chk("ex_mem_en",    bus.ex_mem_en,    e.exmem);
        chk("fwd_a_sel",    bus.fwd_a_sel,    e.fa);
        chk("fwd_b_sel",    bus.fwd_b_sel,    e.fb);
        chk("id_byp_a",     bus.id_byp_a,     e.ba);
        chk("id_byp_b",     bus.id_byp_b,     e.bb);
        chk("ctrl_state",   bus.ctrl_state,   e.st);
        chk("stall_cnt",    bus.stall_cnt,    e.sc);
        chk("flush_cnt",    bus.flush_cnt,    e.fc);
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   cond;
    bit   rdy;
    bit   did_rst;
    did_rst = 0;
    model_reset();
    drive(1'b1);
    // add/sub forwarding at distance 1, 2, 3; load-use; register-0 traffic
    prog.push_back(mk(K_ALU, 1, 0, 0));
    prog.push_back(mk(K_ALU, 2, 0, 0));
    prog.push_back(mk(K_ALU, 3, 6, 7));
    prog.push_back(mk(K_ALU, 4, 3, 1));
    prog.push_back(mk(K_ALU, 3, 6, 7));
    prog.push_back(mk(K_NOP, 0, 0, 0));
    prog.push_back(mk(K_ALU, 4, 3, 1));
    prog.push_back(mk(K_ALU, 3, 6, 7));
    prog.push_back(mk(K_NOP, 0, 0, 0));
    prog.push_back(mk(K_NOP, 0, 0, 0));
    prog.push_back(mk(K_ALU, 4, 3, 1));
    prog.push_back(mk(K_LD,  5, 2, 0));
    prog.push_back(mk(K_ALU, 6, 5, 5));
    prog.push_back(mk(K_ALU, 0, 1, 2));
    prog.push_back(mk(K_ALU, 5, 0, 0));
    prog.push_back(mk(K_LD,  0, 1, 0));
    prog.push_back(mk(K_ALU, 6, 0, 0));
    prog.push_back(mk(K_LD,  7, 1, 0));
    prog.push_back(mk(K_BR,  0, 7, 2));
    prog.push_back(mk(K_JMP, 7, 0, 0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rdy = (cyc < 40) ? 1'b1 : ($urandom_range(0, 99) < 65);
      if (!did_rst && cyc >= 1500 && prev_cond == 3) begin
        reset_n = 1'b0;
        model_reset();
        drive(1'b1);
        #1;
        predict(1'b1, e, cond);
        q.push_back(e);
        @(posedge clk);
        #1 reset_n = 1'b1;
        did_rst = 1;
      end
      drive(rdy);
      predict(rdy, e, cond);
      q.push_back(e);
      @(posedge clk);
      #1;
      advance(e, cond);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("mid_wait_reset_hit", {31'd0, did_rst}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
